// File: rtl/tmr_pkg.sv
// tmr_pkg
//   Shared definitions for the timer_bank peripheral: register offsets inside
//   a channel slot and in the global area, CTRL bit positions, and the byte
//   stride between channel slots.
package tmr_pkg;

  // Offsets inside one 16-byte channel slot (low address nibble)
  localparam logic [3:0] OFF_TH   = 4'h0;
  localparam logic [3:0] OFF_TL   = 4'h4;
  localparam logic [3:0] OFF_CTRL = 4'h8;

  // Global registers (low address byte)
  localparam logic [7:0] OFF_STATUS = 8'h80;
  localparam logic [7:0] OFF_PRESC  = 8'h84;

  // Channel slot stride in bytes and the matching address shift
  localparam int CH_STRIDE = 16;
  localparam int CH_SHIFT  = $clog2(CH_STRIDE);

  // CTRL bit indices
  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_AR   = 2;
  localparam int CTRL_PEND = 3;

endpackage

// File: rtl/timer_channel.sv
// timer_channel
//   One reload timer. Counts up on each prescaler tick while enabled; on
//   overflow from all-ones it reloads from TH and sets PEND, and drops EN
//   unless auto-reload is selected.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   tick            prescaler tick (one cycle wide)
//   th_we/tl_we/ctrl_we  bus write enables for this channel's registers
//   wdata           bus write data
//   th, tl          reload and counter values
//   ctrl            {PEND, AR, IE, EN}
//   irq_req         PEND & IE
module timer_channel
  import tmr_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             th_we,
  input  logic             tl_we,
  input  logic             ctrl_we,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] th,
  output logic [CNT_W-1:0] tl,
  output logic [3:0]       ctrl,
  output logic             irq_req
);

  logic [CNT_W-1:0] th_reg;
  logic [CNT_W-1:0] tl_reg;
  logic             en_reg;
  logic             ie_reg;
  logic             ar_reg;
  logic             pend_reg;

  logic tl_max;
  logic count;
  logic ovf;

  assign tl_max = (tl_reg == {CNT_W{1'b1}});
  // A CPU write to TL on a tick cycle suppresses both increment and overflow.
  assign count  = tick & en_reg & ~tl_we;
  assign ovf    = count & tl_max;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_reg   <= '0;
      tl_reg   <= '0;
      en_reg   <= 1'b0;
      ie_reg   <= 1'b0;
      ar_reg   <= 1'b0;
      pend_reg <= 1'b0;
    end else begin
      if (th_we)
        th_reg <= wdata[CNT_W-1:0];

      // Reload reads th_reg before any same-cycle TH write lands.
      if (tl_we)
        tl_reg <= wdata[CNT_W-1:0];
      else if (count)
        tl_reg <= tl_max ? th_reg : tl_reg + {{(CNT_W-1){1'b0}}, 1'b1};

      // A CTRL write owns EN/IE/AR outright; one-shot auto-clear only
      // applies when software is not writing CTRL that cycle.
      if (ctrl_we) begin
        en_reg <= wdata[CTRL_EN];
        ie_reg <= wdata[CTRL_IE];
        ar_reg <= wdata[CTRL_AR];
      end else if (ovf && !ar_reg) begin
        en_reg <= 1'b0;
      end

      // Hardware set beats software clear.
      if (ovf)
        pend_reg <= 1'b1;
      else if (ctrl_we && wdata[CTRL_PEND])
        pend_reg <= 1'b0;
    end
  end

  assign th      = th_reg;
  assign tl      = tl_reg;
  assign ctrl    = {pend_reg, ar_reg, ie_reg, en_reg};
  assign irq_req = pend_reg & ie_reg;

endmodule

// File: rtl/timer_bank.sv
// timer_bank
//   NUM_CH reload timers behind a shared 16-bit prescaler, memory-mapped on
//   the CPU data bus. Channel n occupies BASE+16*n (TH, TL, CTRL, reserved);
//   STATUS at BASE+0x80, PRESC at BASE+0x84.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   rd, wr       bus strobes
//   addr, wdata  byte address and write data
//   rdata        combinational read data, 0 when rd is low or on a miss
//   irq          registered OR of (PEND & IE) over all channels
module timer_bank
  import tmr_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic       hit;
  logic       wr_hit;
  logic [7:0] off;
  logic [2:0] ch_sel;
  logic       in_ch;

  assign hit    = (addr[31:8] == BASE_ADDR[31:8]) && (addr[1:0] == 2'b00);
  assign wr_hit = wr & hit;
  assign off    = addr[7:0];
  assign ch_sel = off[CH_SHIFT+2:CH_SHIFT];
  assign in_ch  = ~off[7];

  // Prescaler: tick fires when the count reaches PRESC, so the period is
  // PRESC+1 cycles; a PRESC write restarts the count.
  logic [15:0] presc_reg;
  logic [15:0] presc_cnt_reg;
  logic        presc_we;
  logic        tick;

  assign presc_we = wr_hit && (off == OFF_PRESC);
  assign tick     = (presc_cnt_reg == presc_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg     <= '0;
      presc_cnt_reg <= '0;
    end else if (presc_we) begin
      presc_reg     <= wdata[15:0];
      presc_cnt_reg <= '0;
    end else if (tick) begin
      presc_cnt_reg <= '0;
    end else begin
      presc_cnt_reg <= presc_cnt_reg + 16'd1;
    end
  end

  logic [CNT_W-1:0] th_arr   [NUM_CH];
  logic [CNT_W-1:0] tl_arr   [NUM_CH];
  logic [3:0]       ctrl_arr [NUM_CH];
  logic [NUM_CH-1:0] irq_req;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic slot_we;
      assign slot_we = wr_hit && in_ch && (ch_sel == 3'(gi));

      timer_channel #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .th_we   (slot_we && (off[3:0] == OFF_TH)),
        .tl_we   (slot_we && (off[3:0] == OFF_TL)),
        .ctrl_we (slot_we && (off[3:0] == OFF_CTRL)),
        .wdata   (wdata),
        .th      (th_arr[gi]),
        .tl      (tl_arr[gi]),
        .ctrl    (ctrl_arr[gi]),
        .irq_req (irq_req[gi])
      );
    end
  endgenerate

  // Read mux; unpopulated channel slots and the reserved word fall to 0.
  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      if (in_ch) begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (ch_sel == 3'(n)) begin
            case (off[3:0])
              OFF_TH:   rdata = 32'(th_arr[n]);
              OFF_TL:   rdata = 32'(tl_arr[n]);
              OFF_CTRL: rdata = {28'd0, ctrl_arr[n]};
              default:  rdata = '0;
            endcase
          end
        end
      end else if (off == OFF_STATUS) begin
        rdata = 32'(irq_req);
      end else if (off == OFF_PRESC) begin
        rdata = {16'd0, presc_reg};
      end
    end
  end

  logic irq_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      irq_reg <= 1'b0;
    else
      irq_reg <= |irq_req;
  end

  assign irq = irq_reg;

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank
//   Directed bench for timer_bank (NUM_CH=2): reset behaviour, a register
//   write/readback vector table, address decode, and hand-timed sequences for
//   overflow, one-shot, prescaler and write/overflow collisions.
module tb_timer_bank;

  localparam logic [31:0] BASE = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  timer_bank #(
    .NUM_CH    (2),
    .CNT_W     (32),
    .BASE_ADDR (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] exp;
  } rb_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Write commits at the next rising edge; returns 1ns after that edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    @(posedge clk);
    #1;
    wr    = 1'b0;
  endtask

  // Combinational read, consumes 1ns.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    rd   = 1'b1;
    #1;
    d    = rdata;
    rd   = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [12];
    rb_t  rbs  [14];
    logic [31:0] bad_addr [7];

    vecs[0]  = '{BASE + 32'h00, 32'h1234_5678, 32'h1234_5678};
    vecs[1]  = '{BASE + 32'h04, 32'hCAFE_0001, 32'hCAFE_0001};
    vecs[2]  = '{BASE + 32'h08, 32'hFFFF_FFF6, 32'h0000_0006};
    vecs[3]  = '{BASE + 32'h18, 32'h0000_000E, 32'h0000_0006};
    vecs[4]  = '{BASE + 32'h84, 32'hABCD_1234, 32'h0000_1234};
    vecs[5]  = '{BASE + 32'h80, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{BASE + 32'h0C, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7]  = '{BASE + 32'h10, 32'h0000_00FF, 32'h0000_00FF};
    vecs[8]  = '{BASE + 32'h14, 32'h8000_0000, 32'h8000_0000};
    vecs[9]  = '{BASE + 32'h08, 32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{BASE + 32'h84, 32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{BASE + 32'h00, 32'h0000_0000, 32'h0000_0000};

    // Full register image expected after the vector table
    rbs[0]  = '{BASE + 32'h00,  32'h0000_0000};
    rbs[1]  = '{BASE + 32'h04,  32'hCAFE_0001};
    rbs[2]  = '{BASE + 32'h08,  32'h0000_0000};
    rbs[3]  = '{BASE + 32'h0C,  32'h0000_0000};
    rbs[4]  = '{BASE + 32'h10,  32'h0000_00FF};
    rbs[5]  = '{BASE + 32'h14,  32'h8000_0000};
    rbs[6]  = '{BASE + 32'h18,  32'h0000_0006};
    rbs[7]  = '{BASE + 32'h1C,  32'h0000_0000};
    rbs[8]  = '{BASE + 32'h80,  32'h0000_0000};
    rbs[9]  = '{BASE + 32'h84,  32'h0000_0000};
    rbs[10] = '{BASE + 32'h20,  32'h0000_0000};
    rbs[11] = '{BASE + 32'h81,  32'h0000_0000};
    rbs[12] = '{BASE + 32'h100, 32'h0000_0000};
    rbs[13] = '{BASE + 32'h28,  32'h0000_0000};

    bad_addr[0] = BASE + 32'h20;
    bad_addr[1] = BASE + 32'h81;
    bad_addr[2] = BASE + 32'h100;
    bad_addr[3] = BASE + 32'h85;
    bad_addr[4] = BASE + 32'h09;
    bad_addr[5] = BASE + 32'h104;
    bad_addr[6] = BASE + 32'h28;

    // ---------------- reset held with random bus activity
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      addr  = BASE + ($urandom_range(0, 255) & 32'hFC);
      wdata = $urandom;
      wr    = 1'($urandom_range(0, 1));
      rd    = 1'b1;
      #1;
      check($sformatf("reset_rd[%0d]", i), rdata, 32'h0);
      check($sformatf("reset_irq[%0d]", i), {31'd0, irq}, 32'h0);
    end
    rd = 1'b0;
    wr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1);
    check_reg("presc_after_reset", BASE + 32'h84, 32'h0);
    check_reg("ctrl0_after_reset", BASE + 32'h08, 32'h0);

    // ---------------- register write/readback table
    for (int i = 0; i < 12; i++) begin
      logic [31:0] d;
      bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, d);
      check($sformatf("vec[%0d] @%08h", i, vecs[i].addr), d, vecs[i].exp);
    end

    // ---------------- decode: stray writes must not change anything
    for (int i = 0; i < 7; i++)
      bus_write(bad_addr[i], 32'hFFFF_FFFF);
    for (int i = 0; i < 14; i++)
      check_reg($sformatf("readback @%08h", rbs[i].addr), rbs[i].addr, rbs[i].exp);
    addr = BASE + 32'h04;
    rd   = 1'b0;
    #1;
    check("rd_low_zero", rdata, 32'h0);

    // ---------------- overflow with auto-reload (PRESC=0: tick every edge)
    bus_write(BASE + 32'h00, 32'hFFFF_FFF0);
    bus_write(BASE + 32'h04, 32'hFFFF_FFFD);
    bus_write(BASE + 32'h08, 32'h0000_0007);
    step(2);
    check_reg("ar_tl_pre", BASE + 32'h04, 32'hFFFF_FFFF);
    check("ar_irq_pre", {31'd0, irq}, 32'h0);
    step(1);
    check_reg("ar_tl_wrap", BASE + 32'h04, 32'hFFFF_FFF0);
    check_reg("ar_ctrl", BASE + 32'h08, 32'h0000_000F);
    check_reg("ar_status", BASE + 32'h80, 32'h0000_0001);
    check("ar_irq_same_edge", {31'd0, irq}, 32'h0);
    step(1);
    check("ar_irq_next_edge", {31'd0, irq}, 32'h1);
    check_reg("ar_tl_counting", BASE + 32'h04, 32'hFFFF_FFF1);

    // ---------------- one-shot
    bus_write(BASE + 32'h08, 32'h0000_0008);
    bus_write(BASE + 32'h04, 32'hFFFF_FFFD);
    check("os_irq_cleared", {31'd0, irq}, 32'h0);
    bus_write(BASE + 32'h08, 32'h0000_0003);
    step(3);
    check_reg("os_ctrl", BASE + 32'h08, 32'h0000_000A);
    check_reg("os_tl", BASE + 32'h04, 32'hFFFF_FFF0);
    step(20);
    check_reg("os_tl_held", BASE + 32'h04, 32'hFFFF_FFF0);
    check_reg("os_ctrl_held", BASE + 32'h08, 32'h0000_000A);
    check("os_irq", {31'd0, irq}, 32'h1);

    // ---------------- prescaler: PRESC=3, overflow 8 edges after PRESC write
    bus_write(BASE + 32'h08, 32'h0000_0008);
    bus_write(BASE + 32'h10, 32'h0000_0000);
    bus_write(BASE + 32'h84, 32'h0000_0003);
    bus_write(BASE + 32'h14, 32'hFFFF_FFFE);
    bus_write(BASE + 32'h18, 32'h0000_0001);
    step(5);
    check_reg("ps_ctrl_edge7", BASE + 32'h18, 32'h0000_0001);
    check_reg("ps_tl_edge7", BASE + 32'h14, 32'hFFFF_FFFF);
    step(1);
    check_reg("ps_ctrl_edge8", BASE + 32'h18, 32'h0000_0008);
    check_reg("ps_tl_edge8", BASE + 32'h14, 32'h0000_0000);
    check_reg("ps_status", BASE + 32'h80, 32'h0000_0000);
    step(1);
    check("ps_irq", {31'd0, irq}, 32'h0);
    bus_write(BASE + 32'h84, 32'h0000_0000);
    bus_write(BASE + 32'h18, 32'h0000_0008);

    // ---------------- W1C of PEND on the overflow edge
    bus_write(BASE + 32'h00, 32'h0000_0000);
    bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
    bus_write(BASE + 32'h08, 32'h0000_0005);
    step(1);
    bus_write(BASE + 32'h08, 32'h0000_000D);
    check_reg("w1c_ctrl", BASE + 32'h08, 32'h0000_000D);
    check_reg("w1c_tl", BASE + 32'h04, 32'h0000_0000);
    bus_write(BASE + 32'h08, 32'h0000_0008);
    check_reg("w1c_cleared", BASE + 32'h08, 32'h0000_0000);

    // ---------------- TL write on a tick cycle, then EN=0 freeze
    bus_write(BASE + 32'h08, 32'h0000_0001);
    bus_write(BASE + 32'h04, 32'h0000_0005);
    check_reg("tlw_written", BASE + 32'h04, 32'h0000_0005);
    step(1);
    check_reg("tlw_next_tick", BASE + 32'h04, 32'h0000_0006);
    bus_write(BASE + 32'h08, 32'h0000_0000);
    check_reg("freeze_tl", BASE + 32'h04, 32'h0000_0007);
    step(3);
    check_reg("freeze_tl_held", BASE + 32'h04, 32'h0000_0007);

    // ---------------- TH write on the overflow edge reloads old TH
    bus_write(BASE + 32'h00, 32'h0000_0010);
    bus_write(BASE + 32'h04, 32'hFFFF_FFFE);
    bus_write(BASE + 32'h08, 32'h0000_0005);
    step(1);
    bus_write(BASE + 32'h00, 32'h0000_0020);
    check_reg("thw_tl_old_th", BASE + 32'h04, 32'h0000_0010);
    check_reg("thw_th_new", BASE + 32'h00, 32'h0000_0020);
    bus_write(BASE + 32'h08, 32'h0000_0008);

    // ---------------- asynchronous reset mid-count
    bus_write(BASE + 32'h04, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h08, 32'h0000_0007);
    step(2);
    check("mid_irq_before", {31'd0, irq}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_irq_after", {31'd0, irq}, 32'h0);
    check_reg("mid_th", BASE + 32'h00, 32'h0);
    check_reg("mid_tl", BASE + 32'h04, 32'h0);
    check_reg("mid_ctrl", BASE + 32'h08, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(2);
    check_reg("post_tl", BASE + 32'h04, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
